// File: rtl/dcache_lru_pkg.sv
// rtl/dcache_lru_pkg.sv - tree-PLRU constants, FSM states and victim/touch helpers
package dcache_lru_pkg;

  localparam int LOG2_WAYS_DEF = 2;
  localparam int WAYS_DEF      = 1 << LOG2_WAYS_DEF;
  localparam int STATE_W_DEF   = WAYS_DEF - 1;

  // Helpers work on the widest supported tree; callers pad and pass their own depth.
  localparam int MAX_LOG2_WAYS = 4;
  localparam int MAX_STATE_W   = (1 << MAX_LOG2_WAYS) - 1;

  typedef logic [MAX_STATE_W-1:0]   plru_state_t;
  typedef logic [MAX_LOG2_WAYS-1:0] plru_way_t;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } plru_fsm_t;

  function automatic plru_way_t plru_victim(input plru_state_t state, input int log2_ways);
    plru_way_t   way;
    plru_state_t sh;
    int          node;
    way  = '0;
    node = 1;
    for (int lvl = 0; lvl < MAX_LOG2_WAYS; lvl++) begin
      if (lvl < log2_ways) begin
        sh   = state >> (node - 1);
        way  = {way[MAX_LOG2_WAYS-2:0], sh[0]};
        node = 2 * node + int'(sh[0]);
      end
    end
    return way;
  endfunction

  function automatic plru_state_t plru_touch(input plru_state_t state, input plru_way_t way,
                                             input int log2_ways);
    plru_state_t nxt;
    plru_state_t one;
    plru_way_t   wsh;
    int          node;
    nxt  = state;
    one  = plru_state_t'(1);
    node = 1;
    for (int lvl = 0; lvl < MAX_LOG2_WAYS; lvl++) begin
      if (lvl < log2_ways) begin
        wsh = way >> (log2_ways - 1 - lvl);
        if (wsh[0]) nxt = nxt & ~(one << (node - 1));
        else        nxt = nxt | (one << (node - 1));
        node = 2 * node + int'(wsh[0]);
      end
    end
    return nxt;
  endfunction

endpackage

// File: rtl/dcache_plru_updater_if.sv
// rtl/dcache_plru_updater_if.sv - request/response and LRU RAM port bundle
interface dcache_plru_updater_if #(
  parameter int LOG2_WAYS  = 2,
  parameter int INDEX_BITS = 8
);
  logic                          req_valid;
  logic                          req_ready;
  logic                          req_alloc;
  logic [INDEX_BITS-1:0]         req_index;
  logic [LOG2_WAYS-1:0]          req_way;
  logic                          rsp_valid;
  logic [LOG2_WAYS-1:0]          rsp_way;
  logic                          lru_rden;
  logic [INDEX_BITS-1:0]         lru_rdaddress;
  logic [(1<<LOG2_WAYS)-2:0]     lru_q;
  logic                          lru_wren;
  logic [INDEX_BITS-1:0]         lru_wraddress;
  logic [(1<<LOG2_WAYS)-2:0]     lru_data;

  modport master (
    output req_valid, req_alloc, req_index, req_way, lru_q,
    input  req_ready, rsp_valid, rsp_way, lru_rden, lru_rdaddress,
           lru_wren, lru_wraddress, lru_data
  );

  modport slave (
    input  req_valid, req_alloc, req_index, req_way, lru_q,
    output req_ready, rsp_valid, rsp_way, lru_rden, lru_rdaddress,
           lru_wren, lru_wraddress, lru_data
  );
endinterface

// File: rtl/dcache_plru_tree.sv
// rtl/dcache_plru_tree.sv - combinational PLRU step: state in -> way and updated state
module dcache_plru_tree
  import dcache_lru_pkg::*;
#(
  parameter int LOG2_WAYS = 2
) (
  input  logic [(1<<LOG2_WAYS)-2:0] state,
  input  logic                      alloc,
  input  logic [LOG2_WAYS-1:0]      hit_way,
  output logic [LOG2_WAYS-1:0]      way,
  output logic [(1<<LOG2_WAYS)-2:0] next_state
);
  localparam int WAYS = 1 << LOG2_WAYS;

  plru_state_t state_ext;
  plru_state_t next_ext;
  plru_way_t   victim_ext;
  plru_way_t   touch_ext;

  always_comb begin
    state_ext  = plru_state_t'(state);
    victim_ext = plru_victim(state_ext, LOG2_WAYS);
    touch_ext  = alloc ? victim_ext : plru_way_t'(hit_way);
    next_ext   = plru_touch(state_ext, touch_ext, LOG2_WAYS);
  end

  assign way        = touch_ext[LOG2_WAYS-1:0];
  assign next_state = next_ext[WAYS-2:0];

  // Padding bits above this tree's depth always stay zero.
  generate
    if (LOG2_WAYS < MAX_LOG2_WAYS) begin : g_pad
      logic unused_hi;
      assign unused_hi = ^{touch_ext[MAX_LOG2_WAYS-1:LOG2_WAYS], next_ext[MAX_STATE_W-1:WAYS-1]};
    end
  endgenerate
endmodule

// File: rtl/dcache_plru_updater.sv
// rtl/dcache_plru_updater.sv - PLRU read-modify-write updater; DCACHE_PLRU_BYPASS_EN forwards same-index state instead of stalling
module dcache_plru_updater
  import dcache_lru_pkg::*;
#(
  parameter int LOG2_WAYS  = 2,
  parameter int INDEX_BITS = 8
) (
  input  logic                 clock,
  input  logic                 aclr,
  dcache_plru_updater_if.slave bus
);
  localparam int STATE_W = (1 << LOG2_WAYS) - 1;

  plru_fsm_t              state;
  plru_fsm_t              state_nxt;
  logic [INDEX_BITS-1:0]  init_cnt;
  logic                   s1_valid;
  logic                   s1_alloc;
  logic [INDEX_BITS-1:0]  s1_index;
  logic [LOG2_WAYS-1:0]   s1_way;
  logic [STATE_W-1:0]     tree_in;
  logic [STATE_W-1:0]     tree_out;
  logic [LOG2_WAYS-1:0]   tree_way;
  logic                   same_stall;
  logic                   ready;
  logic                   accept;

`ifdef DCACHE_PLRU_BYPASS_EN
  logic                   byp_valid;
  logic [INDEX_BITS-1:0]  byp_index;
  logic [STATE_W-1:0]     byp_data;

  // RAM read of the same set was issued before last cycle's write landed.
  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      byp_valid <= 1'b0;
      byp_index <= '0;
      byp_data  <= '0;
    end else begin
      byp_valid <= s1_valid;
      byp_index <= s1_index;
      byp_data  <= tree_out;
    end
  end

  assign tree_in    = (byp_valid && (byp_index == s1_index)) ? byp_data : bus.lru_q;
  assign same_stall = 1'b0;
`else
  assign tree_in    = bus.lru_q;
  assign same_stall = s1_valid && (bus.req_index == s1_index);
`endif

  dcache_plru_tree #(.LOG2_WAYS(LOG2_WAYS)) u_tree (
    .state      (tree_in),
    .alloc      (s1_alloc),
    .hit_way    (s1_way),
    .way        (tree_way),
    .next_state (tree_out)
  );

  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) state <= ST_INIT;
    else      state <= state_nxt;
  end

  always_ff @(posedge clock or posedge aclr) begin
    if (aclr)                  init_cnt <= '0;
    else if (state == ST_INIT) init_cnt <= init_cnt + 1'b1;
  end

  always_comb begin
    state_nxt         = state;
    ready             = 1'b0;
    bus.lru_rden      = 1'b0;
    bus.lru_rdaddress = '0;
    bus.lru_wren      = 1'b0;
    bus.lru_wraddress = '0;
    bus.lru_data      = '0;
    bus.rsp_valid     = 1'b0;
    bus.rsp_way       = '0;
    // Every output is forced low while reset is held, including the INIT sweep.
    if (!aclr) begin
      case (state)
        ST_INIT: begin
          bus.lru_wren      = 1'b1;
          bus.lru_wraddress = init_cnt;
          if (&init_cnt) state_nxt = ST_RUN;
        end
        ST_RUN: begin
          ready             = !same_stall;
          bus.lru_rden      = !same_stall && bus.req_valid;
          bus.lru_rdaddress = (!same_stall && bus.req_valid) ? bus.req_index : '0;
          bus.lru_wren      = s1_valid;
          bus.lru_wraddress = s1_valid ? s1_index : '0;
          bus.lru_data      = s1_valid ? tree_out : '0;
          bus.rsp_valid     = s1_valid;
          bus.rsp_way       = s1_valid ? tree_way : '0;
        end
        default: state_nxt = ST_INIT;
      endcase
    end
    bus.req_ready = ready;
  end

  assign accept = ready && bus.req_valid;

  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      s1_valid <= 1'b0;
      s1_alloc <= 1'b0;
      s1_index <= '0;
      s1_way   <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_alloc <= bus.req_alloc;
        s1_index <= bus.req_index;
        s1_way   <= bus.req_way;
      end
    end
  end
endmodule
